// File: rtl/lcd_pkg.sv
// Shared types and constants for the character-LCD sequencing controller.
package lcd_pkg;

  typedef enum logic [2:0] {
    RST_HOLD,
    PWR_WAIT,
    LOAD,
    SETUP,
    PULSE,
    HOLD,
    IDLE
  } state_t;

  // Power-on command list: 8-bit/2-line, display on, entry increment, clear.
  localparam logic [7:0] INIT_CMD [4] = '{8'h38, 8'h0C, 8'h06, 8'h01};
  localparam logic [1:0] INIT_LAST    = 2'd3;
  localparam logic [7:0] CMD_CLEAR    = 8'h01;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_timer.sv
// Loadable down-counter; done is high during the last cycle of a loaded interval.
module lcd_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done,
  output logic         zero
);

  logic [W-1:0] count;

  // NOTE: registers are assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign done = (count == W'(1));
  assign zero = (count == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// Character-LCD controller: panel reset, power-up wait, init commands, then
// one handshaked byte at a time with setup / enable / post-write timing.
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int T_RST  = 1000,
  parameter int T_PWR  = 20000,
  parameter int T_SU   = 4,
  parameter int T_EN   = 12,
  parameter int T_WAIT = 2500,
  parameter int T_CLR  = 90000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  input  logic       req_rs,
  input  logic [7:0] req_data,
  output logic       req_ready,
  output logic       init_done,
  output logic       lcd_en,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [7:0] lcd_db,
  output logic       lcd_rst
);

  localparam int T_MAX = max_of(max_of(max_of(T_RST, T_PWR), max_of(T_SU, T_EN)),
                                max_of(T_WAIT, T_CLR));
  localparam int CW    = $clog2(T_MAX) + 1;

  state_t          state;
  logic [1:0]      idx;
  logic            tmr_load;
  logic [CW-1:0]   tmr_val;
  logic            tmr_done;
  logic            tmr_zero;
  logic            is_clear;
  logic            accept;

  assign lcd_rw   = 1'b0;
  assign is_clear = !lcd_rs && (lcd_db == CMD_CLEAR);
  assign accept   = req_valid && req_ready;

  // Reset leaves the counter at zero, so RST_HOLD spends its first cycle
  // loading T_RST-1; its total length is still T_RST cycles (T_RST >= 2).
  // NOTE: every output gets a default first, so no path infers a latch.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state)
      RST_HOLD: begin
        if (tmr_zero) begin
          tmr_load = 1'b1;
          tmr_val  = CW'(T_RST - 1);
        end else if (tmr_done) begin
          tmr_load = 1'b1;
          tmr_val  = CW'(T_PWR);
        end
      end
      LOAD: begin
        tmr_load = 1'b1;
        tmr_val  = CW'(T_SU);
      end
      SETUP: begin
        tmr_load = tmr_done;
        tmr_val  = CW'(T_EN);
      end
      PULSE: begin
        tmr_load = tmr_done;
        tmr_val  = is_clear ? CW'(T_CLR) : CW'(T_WAIT);
      end
      IDLE: begin
        tmr_load = accept;
        tmr_val  = CW'(T_SU);
      end
      default: ;
    endcase
  end

  lcd_timer #(.W(CW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= RST_HOLD;
      idx       <= '0;
      lcd_en    <= 1'b0;
      lcd_rs    <= 1'b0;
      lcd_db    <= '0;
      lcd_rst   <= 1'b0;
      req_ready <= 1'b0;
      init_done <= 1'b0;
    end else begin
      case (state)
        RST_HOLD: if (tmr_done) begin
          state   <= PWR_WAIT;
          lcd_rst <= 1'b1;
        end
        PWR_WAIT: if (tmr_done) state <= LOAD;
        LOAD: begin
          lcd_rs <= 1'b0;
          lcd_db <= INIT_CMD[idx];
          state  <= SETUP;
        end
        SETUP: if (tmr_done) begin
          lcd_en <= 1'b1;
          state  <= PULSE;
        end
        PULSE: if (tmr_done) begin
          lcd_en <= 1'b0;
          state  <= HOLD;
        end
        HOLD: if (tmr_done) begin
          if (!init_done && idx != INIT_LAST) begin
            idx   <= idx + 2'd1;
            state <= LOAD;
          end else begin
            init_done <= 1'b1;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        IDLE: if (accept) begin
          lcd_rs    <= req_rs;
          lcd_db    <= req_data;
          req_ready <= 1'b0;
          state     <= SETUP;
        end
        default: state <= RST_HOLD;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_ctrl.sv
// Scoreboard bench for lcd_ctrl: stimulus pushes expected LCD writes, a
// monitor pops one per enable pulse and checks bus, pulse width and gaps.
module tb_lcd_ctrl;

  localparam int T_RST  = 3;
  localparam int T_PWR  = 5;
  localparam int T_SU   = 2;
  localparam int T_EN   = 3;
  localparam int T_WAIT = 4;
  localparam int T_CLR  = 10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_rs;
  logic [7:0] req_data;
  logic       req_ready;
  logic       init_done;
  logic       lcd_en;
  logic       lcd_rs;
  logic       lcd_rw;
  logic [7:0] lcd_db;
  logic       lcd_rst;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       rs;
    logic [7:0] db;
    int         gap;        // low samples after the pulse until next rise / ready
    bit         is_init;
    bit         last_init;
  } item_t;

  item_t exp_q[$];

  always #5 clk = ~clk;

  lcd_ctrl #(
    .T_RST(T_RST), .T_PWR(T_PWR), .T_SU(T_SU),
    .T_EN(T_EN), .T_WAIT(T_WAIT), .T_CLR(T_CLR)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_rs    (req_rs),
    .req_data  (req_data),
    .req_ready (req_ready),
    .init_done (init_done),
    .lcd_en    (lcd_en),
    .lcd_rs    (lcd_rs),
    .lcd_rw    (lcd_rw),
    .lcd_db    (lcd_db),
    .lcd_rst   (lcd_rst)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: unexpected event (t=%0t)", name, $time);
  endtask

  // Reference model: wait after a write is the clear time only for rs=0/0x01.
  function automatic int post_wait(input logic rs, input logic [7:0] db);
    return (!rs && db == 8'h01) ? T_CLR : T_WAIT;
  endfunction

  task automatic push_init();
    logic [7:0] cmds [4];
    cmds = '{8'h38, 8'h0C, 8'h06, 8'h01};
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back('{rs: 1'b0, db: cmds[i],
                        gap: post_wait(1'b0, cmds[i]) + ((i < 3) ? (1 + T_SU) : 0),
                        is_init: 1'b1, last_init: (i == 3)});
    end
  endtask

  task automatic push_req(input logic rs, input logic [7:0] d);
    exp_q.push_back('{rs: rs, db: d, gap: post_wait(rs, d), is_init: 1'b0, last_init: 1'b0});
  endtask

  // Called on a negedge; returns on the negedge right after the accept edge.
  task automatic complete(input bit keep);
    int k = 0;
    while (!req_ready && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (!req_ready) begin
      check("ready_timeout", req_ready, 1);
      req_valid = 1'b0;
      return;
    end
    check("init_before_accept", init_done, 1);
    @(negedge clk);
    check("ready_drops_after_accept", req_ready, 0);
    if (!keep) req_valid = 1'b0;
  endtask

  task automatic send(input logic rs, input logic [7:0] d, input bit keep);
    push_req(rs, d);
    req_valid = 1'b1;
    req_rs    = rs;
    req_data  = d;
    complete(keep);
  endtask

  task automatic do_reset(input bit pre_req, input logic rs, input logic [7:0] d);
    int n;
    int m;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_en", lcd_en, 0);
    check("rst_rs", lcd_rs, 0);
    check("rst_db", lcd_db, 0);
    check("rst_rw", lcd_rw, 0);
    check("rst_lcd_rst", lcd_rst, 0);
    check("rst_ready", req_ready, 0);
    check("rst_init_done", init_done, 0);
    exp_q.delete();
    push_init();
    if (pre_req) begin
      push_req(rs, d);
      req_valid = 1'b1;
      req_rs    = rs;
      req_data  = d;
    end
    rst_n = 1'b1;
    n = 1;
    while (n < 50) begin
      @(negedge clk);
      if (lcd_rst) break;
      n++;
    end
    check("lcd_rst_low_cycles", n, T_RST);
    m = 0;
    while (!lcd_en && m < 500) begin
      @(negedge clk);
      m++;
    end
    check("first_en_delay", m, T_PWR + 1 + T_SU);
  endtask

  initial begin : monitor
    item_t cur;
    logic  prev_en;
    bit    in_gap;
    bit    acc_prev;
    int    high_cnt;
    int    low_cnt;
    int    since_acc;
    cur = '{rs: 1'b0, db: 8'h00, gap: 0, is_init: 1'b0, last_init: 1'b0};
    prev_en = 1'b0; in_gap = 1'b0; acc_prev = 1'b0;
    high_cnt = 0; low_cnt = 0; since_acc = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_en = 1'b0; in_gap = 1'b0; acc_prev = 1'b0;
        high_cnt = 0; low_cnt = 0; since_acc = 0;
      end else begin
        check("ready_while_en", 32'(req_ready && lcd_en), 0);
        if (acc_prev) begin
          since_acc = 1;
          if (exp_q.size() == 0) fail_now("accept_without_request");
          else begin
            check("accept_rs", lcd_rs, exp_q[0].rs);
            check("accept_db", lcd_db, exp_q[0].db);
          end
        end else begin
          since_acc++;
        end

        if (lcd_en && !prev_en) begin
          if (in_gap) begin
            check("gap_to_next_en", low_cnt, cur.gap);
            in_gap = 1'b0;
          end
          if (exp_q.size() == 0) fail_now("extra_pulse");
          else begin
            cur = exp_q.pop_front();
            check("pulse_rs", lcd_rs, cur.rs);
            check("pulse_db", lcd_db, cur.db);
            check("pulse_rw", lcd_rw, 0);
            check("init_done_at_pulse", init_done, 32'(!cur.is_init));
            if (!cur.is_init) check("accept_to_en", since_acc, T_SU + 1);
          end
          high_cnt = 1;
        end else if (lcd_en) begin
          high_cnt++;
          check("bus_rs_stable", lcd_rs, cur.rs);
          check("bus_db_stable", lcd_db, cur.db);
        end else if (prev_en) begin
          check("en_width", high_cnt, T_EN);
          in_gap  = 1'b1;
          low_cnt = 1;
        end else if (in_gap) begin
          if (req_ready) begin
            check("gap_to_ready", low_cnt, cur.gap);
            if (cur.last_init) check("init_done_rise", init_done, 1);
            in_gap = 1'b0;
          end else begin
            low_cnt++;
          end
        end
        acc_prev = req_valid && req_ready;
        prev_en  = lcd_en;
      end
    end
  end

  initial begin : stimulus
    int   k;
    logic rs;
    logic [7:0] d;
    rst_n = 1'b0; req_valid = 1'b0; req_rs = 1'b0; req_data = 8'h00;

    do_reset(1'b0, 1'b0, 8'h00);
    send(1'b1, 8'h41, 1'b0);
    send(1'b1, 8'h48, 1'b1);
    send(1'b1, 8'h69, 1'b0);
    send(1'b0, 8'h01, 1'b0);
    send(1'b0, 8'h80, 1'b0);

    for (int i = 0; i < 16; i++) begin
      rs = 1'($urandom_range(0, 1));
      d  = ($urandom_range(0, 3) == 0) ? 8'h01 : 8'($urandom);
      send(rs, d, 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of an enable pulse, with a request already waiting.
    send(1'b1, 8'h55, 1'b0);
    k = 0;
    while (!lcd_en && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("reached_pulse", lcd_en, 1);
    do_reset(1'b1, 1'b1, 8'h5A);
    complete(1'b0);
    send(1'b0, 8'h01, 1'b0);
    send(1'b1, 8'h7E, 1'b0);

    k = 0;
    while (!req_ready && k < 500) begin
      @(negedge clk);
      k++;
    end
    repeat (2) @(negedge clk);
    check("final_ready", req_ready, 1);
    check("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lcd_ctrl.md
Name: lcd_ctrl

Overview:
- Sequencing controller for the character LCD port (lcd_en, lcd_rs, lcd_rw, lcd_db, lcd_rst).
- After reset it holds the panel in reset, waits for power-up, then issues a fixed four-command init sequence.
- After init it accepts one byte at a time (command or data) from a requester over a valid/ready handshake. It generates the setup, enable-pulse and post-write wait timing for each byte.
- Sits between the text/display-content logic and the LCD pins.

Parameters:
- T_RST, 1000: cycles lcd_rst is held low after reset release.
- T_PWR, 20000: cycles waited after lcd_rst rises, before the first init command.
- T_SU, 4: cycles lcd_rs/lcd_db are stable with lcd_en=0 before the enable pulse.
- T_EN, 12: cycles lcd_en is high per byte.
- T_WAIT, 2500: cycles with lcd_en=0 after the pulse, for normal bytes.
- T_CLR, 90000: cycles with lcd_en=0 after the pulse, for the clear command (rs=0, data=0x01).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  1  requester has a byte.
- req_rs  in  1  0 = command, 1 = data.
- req_data  in  8  byte to write.
- req_ready  out  1  controller can accept a byte.
- init_done  out  1  high once the init sequence is complete.
- lcd_en  out  1  LCD enable strobe.
- lcd_rs  out  1  LCD register select.
- lcd_rw  out  1  constant 0 (write only).
- lcd_db  out  8  LCD data bus.
- lcd_rst  out  1  LCD reset, active low.

Behaviour:
- Reset: synchronous on the clk edge while rst_n=0.
  - State = RST_HOLD; counter = 0; init index = 0.
  - Outputs: lcd_en=0, lcd_rs=0, lcd_db=0x00, lcd_rst=0, req_ready=0, init_done=0.
  - lcd_rw is 0 at all times.
- All outputs are registered. Reset asserted in any state (including mid-pulse) returns to reset values on the next edge.
- One shared down-counter, width = clog2(max parameter)+1. A timed state lasts exactly its parameter's count of cycles, loaded on entry.
- States and transitions:
  - RST_HOLD: lcd_rst=0 for T_RST cycles, then go to PWR_WAIT with lcd_rst=1.
  - PWR_WAIT: T_PWR cycles, then go to LOAD.
  - LOAD: load lcd_rs=0 and lcd_db=INIT_CMD[idx], then go to SETUP. Takes 1 cycle.
  - SETUP: T_SU cycles, lcd_en=0, then go to PULSE.
  - PULSE: T_EN cycles, lcd_en=1, then go to HOLD.
  - HOLD: lcd_en=0 for T_CLR cycles if the latched byte is rs=0/0x01, otherwise T_WAIT cycles. Then:
    - if still initializing and idx<3: idx++ and go to LOAD;
    - if idx==3: set init_done=1 and go to IDLE;
    - after init: go to IDLE.
  - IDLE: req_ready=1. On req_valid & req_ready, latch req_rs/req_data onto lcd_rs/lcd_db on that edge, drop req_ready, and go to SETUP.
- req_ready is high only in IDLE, so it is never high while lcd_en=1.
- lcd_rs/lcd_db stay constant from entry to SETUP until the next accept or LOAD. They hold their last value in IDLE.
- Once high, init_done stays high until reset.
- Requests presented before init_done are not accepted. req_valid may stay high; it is accepted on the first IDLE cycle.
- Requester rule: must hold req_valid, req_rs and req_data stable until accepted. The controller samples only on the accept edge.
- Byte period (accept edge to the next req_ready=1) = T_SU + T_EN + T_WAIT cycles, or T_SU + T_EN + T_CLR for a clear.
- Back-to-back: if req_valid is already high when IDLE is entered, accept happens in that first IDLE cycle. Throughput is one byte per byte period plus 1 cycle.

Decomposition:
- Package lcd_pkg:
  - state enum {RST_HOLD, PWR_WAIT, LOAD, SETUP, PULSE, HOLD, IDLE};
  - INIT_CMD array {0x38 function set 8-bit/2-line, 0x0C display on, 0x06 entry mode inc, 0x01 clear};
  - CMD_CLEAR = 0x01.
- One natural sub-module: lcd_timer, a loadable down-counter with a done flag, used by every timed state.

Test Plan (override T_RST=3, T_PWR=5, T_SU=2, T_EN=3, T_WAIT=4, T_CLR=10):
- Reset then release -> lcd_rst low exactly 3 cycles, then high. First lcd_en rise exactly 5+1+2 cycles after lcd_rst rises, with lcd_db=0x38, lcd_rs=0.
- Init sequence -> four 3-cycle en pulses with db = 0x38, 0x0C, 0x06, 0x01. Gaps: 4 low cycles after each of the first three pulses, 10 after 0x01. init_done rises after the last gap; req_ready=1 in the same cycle.
- Data write: req_valid=1, rs=1, data=0x41 while ready -> db=0x41 and rs=1 next cycle. en high for 3 cycles starting 2 cycles later. req_ready returns 1 after 2+3+4 cycles.
- Back-to-back 'H','i' (0x48, 0x69) with req_valid held high -> second accept in the first IDLE cycle. 0x69 stays on the bus through its full pulse; no extra pulse occurs.
- Command 0x01 after init -> post-pulse wait of 10 cycles before req_ready. Command 0x80 -> wait of 4 cycles.
- rst_n=0 during PULSE -> next edge gives lcd_en=0, lcd_rst=0, init_done=0, req_ready=0, and the full init sequence replays after release. req_valid held high during init is not accepted before init_done.
